// File: rtl/draw_stream_mux_pkg.sv
// Shared opcode, FSM-state and colour constants for the draw-colour stream blocks.
package gpu_draw_pkg;

   localparam logic [3:0] OP_CF   = 4'd0;
   localparam logic [3:0] OP_CD   = 4'd1;
   localparam logic [3:0] OP_RF   = 4'd2;
   localparam logic [3:0] OP_RD   = 4'd3;
   localparam logic [3:0] OP_LD   = 4'd4;
   localparam logic [3:0] OP_FU   = 4'd10;
   localparam logic [3:0] OP_IDLE = 4'd15;

   localparam logic [15:0] FAULT_COLOUR = 16'hF000;

   typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_FAULT} state_t;

endpackage

// File: rtl/draw_stream_mux_if.sv
// Engine-side and framebuffer-side stream bundle of draw_stream_mux; the mux takes the slave view.
interface draw_stream_if #(
   parameter int NCH   = 5,
   parameter int CW    = 16,
   parameter int SEL_W = 4
);
   logic [NCH-1:0]         in_valid;
   logic [NCH-1:0]         in_ready;
   logic [NCH-1:0][CW-1:0] in_colour;
   logic [NCH-1:0]         in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [CW-1:0]          out_colour;
   logic                   out_last;
   logic [SEL_W-1:0]       out_src;

   modport master (
      output in_valid, in_colour, in_last, out_ready,
      input  in_ready, out_valid, out_colour, out_last, out_src
   );

   modport slave (
      input  in_valid, in_colour, in_last, out_ready,
      output in_ready, out_valid, out_colour, out_last, out_src
   );
endinterface

// File: rtl/draw_stream_mux_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   int  c;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int i = 1; i <= N; i++) begin
         c = (int'(ptr) + i) % N;
         if (!found && req[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            idx    = IW'(c);
         end
      end
   end
endmodule

// File: rtl/draw_stream_mux.sv
// Burst-granular arbiter/mux from NCH draw engines to one registered valid/ready stream.
// Optional beat counter port enabled by defining DRAW_MUX_BEATCNT_EN.
module draw_stream_mux
   import gpu_draw_pkg::*;
#(
   parameter int              NCH     = 5,
   parameter int              CW      = 16,
   parameter int              SEL_W   = 4,
   parameter logic [CW-1:0]   FAULT_C = CW'(FAULT_COLOUR)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             arb_mode,
   input  logic [SEL_W-1:0] sel,
   draw_stream_if.slave     bus,
   output logic             busy,
   output logic             fault
`ifdef DRAW_MUX_BEATCNT_EN
   ,
   output logic [31:0]      beat_cnt
`endif
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   state_t           state, state_n;
   logic [IW-1:0]    grant, grant_n, rr_ptr, ptr_n;
   logic             out_valid, ov_n, out_last, last_n, fault_q, fault_n;
   logic [CW-1:0]    out_colour, col_n;
   logic [SEL_W-1:0] out_src, src_n, fault_sel, fsel_n;
   logic [NCH-1:0]   in_ready, arb_gnt;
   logic [IW-1:0]    arb_idx, sel_idx;
   logic             out_free, sel_ok, sel_quiet;

   rr_arbiter #(.N(NCH), .IW(IW)) u_arb (
      .req (bus.in_valid),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign out_free  = !out_valid || bus.out_ready;
   assign sel_ok    = sel < SEL_W'(NCH);
   assign sel_idx   = sel[IW-1:0];
   assign sel_quiet = (sel == SEL_W'(OP_FU)) || (sel == SEL_W'(OP_IDLE));

   always_comb begin
      state_n  = state;
      grant_n  = grant;
      ptr_n    = rr_ptr;
      ov_n     = out_valid;
      col_n    = out_colour;
      last_n   = out_last;
      src_n    = out_src;
      fault_n  = fault_q;
      fsel_n   = fault_sel;
      in_ready = '0;
      if (out_valid && bus.out_ready) ov_n = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (arb_mode) begin
               if (|arb_gnt) begin
                  state_n = ST_LOCKED;
                  grant_n = arb_idx;
               end
            end else if (sel_ok) begin
               if (bus.in_valid[sel_idx]) begin
                  state_n = ST_LOCKED;
                  grant_n = sel_idx;
               end
            end else if (!sel_quiet) begin
               // Latch the offending opcode so out_src survives later sel changes.
               state_n = ST_FAULT;
               fsel_n  = sel;
            end
         end
         ST_LOCKED: begin
            in_ready[grant] = out_free;
            if (bus.in_valid[grant] && out_free) begin
               ov_n   = 1'b1;
               col_n  = bus.in_colour[grant];
               last_n = bus.in_last[grant];
               src_n  = SEL_W'(grant);
               if (bus.in_last[grant]) begin
                  state_n = ST_IDLE;
                  ptr_n   = grant;
               end
            end
         end
         ST_FAULT: begin
            if (out_free) begin
               ov_n    = 1'b1;
               col_n   = FAULT_C;
               last_n  = 1'b1;
               src_n   = fault_sel;
               fault_n = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         grant      <= '0;
         rr_ptr     <= IW'(NCH - 1);
         out_valid  <= 1'b0;
         out_colour <= '0;
         out_last   <= 1'b0;
         out_src    <= '0;
         fault_q    <= 1'b0;
         fault_sel  <= '0;
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         rr_ptr     <= ptr_n;
         out_valid  <= ov_n;
         out_colour <= col_n;
         out_last   <= last_n;
         out_src    <= src_n;
         fault_q    <= fault_n;
         fault_sel  <= fsel_n;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_colour = out_colour;
   assign bus.out_last   = out_last;
   assign bus.out_src    = out_src;
   assign busy           = (state != ST_IDLE) || out_valid;
   assign fault          = fault_q;

`ifdef DRAW_MUX_BEATCNT_EN
   logic [31:0] beat_cnt_r;

   always_ff @(posedge CLK) begin
      if (RST)                            beat_cnt_r <= '0;
      else if (out_valid && bus.out_ready) beat_cnt_r <= beat_cnt_r + 32'd1;
   end

   assign beat_cnt = beat_cnt_r;
`endif
endmodule

// File: tb/tb_draw_stream_mux.sv
// Bench for draw_stream_mux: opcode vector table plus scoreboarded burst sequences.
module tb_draw_stream_mux;
   localparam int NCH = 5;
   localparam int CW  = 16;
   localparam int SW  = 4;

   typedef struct packed {logic [CW-1:0] colour; logic last;} beat_t;
   typedef struct packed {logic [CW-1:0] colour; logic last; logic [SW-1:0] src;} exp_t;
   typedef struct {
      logic arb; logic [SW-1:0] sel; logic [NCH-1:0] vmask;
      logic ov; logic [CW-1:0] colour; logic [SW-1:0] src; logic flt;
   } vec_t;

   logic clk = 1'b0;
   logic rst, arb_mode, busy, fault;
   logic [SW-1:0] sel;
`ifdef DRAW_MUX_BEATCNT_EN
   logic [31:0] beat_cnt;
`endif

   draw_stream_if #(.NCH(NCH), .CW(CW), .SEL_W(SW)) bus ();

   draw_stream_mux #(.NCH(NCH), .CW(CW), .SEL_W(SW)) dut (
      .CLK      (clk),
      .RST      (rst),
      .arb_mode (arb_mode),
      .sel      (sel),
      .bus      (bus),
      .busy     (busy),
      .fault    (fault)
`ifdef DRAW_MUX_BEATCNT_EN
      ,
      .beat_cnt (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int     errors = 0, checks = 0, cyc = 0, seen = 0;
   beat_t  eng_q[NCH][$];
   exp_t   exp_q[$];
   int     tq[$];
   logic   raw;
   logic [NCH-1:0] raw_valid;
   vec_t   tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push_burst(input int ch, input int n, input logic [CW-1:0] base);
      for (int k = 0; k < n; k++) begin
         eng_q[ch].push_back('{colour: base + CW'(k), last: (k == n - 1)});
         exp_q.push_back('{colour: base + CW'(k), last: (k == n - 1), src: SW'(ch)});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk({name, "_drain_left"}, exp_q.size(), 0);
   endtask

   task automatic wait_seen(input int target, input string name);
      int n;
      n = 0;
      while (seen < target && n < 50) begin
         tick();
         n++;
      end
      chk({name, "_seen"}, (seen >= target), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tq.delete();
      seen = 0;
   endtask

   // Engine models: present queue fronts shortly after each rising edge.
   initial begin
      bus.in_valid  = '0;
      bus.in_colour = '0;
      bus.in_last   = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NCH; i++) begin
            if (raw) begin
               bus.in_valid[i]  = raw_valid[i];
               bus.in_colour[i] = CW'(16'h1000 + i);
               bus.in_last[i]   = 1'b1;
            end else if (eng_q[i].size() != 0) begin
               bus.in_valid[i]  = 1'b1;
               bus.in_colour[i] = eng_q[i][0].colour;
               bus.in_last[i]   = eng_q[i][0].last;
            end else begin
               bus.in_valid[i]  = 1'b0;
               bus.in_colour[i] = '0;
               bus.in_last[i]   = 1'b0;
            end
         end
      end
   end

   // Handshake monitor at the falling edge: scoreboard out beats, retire accepted engine beats.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst && !raw) begin
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got colour %h src %0d, none expected",
                           bus.out_colour, bus.out_src);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_colour", 32'(bus.out_colour), 32'(e.colour));
                  chk("sb_last",   32'(bus.out_last),   32'(e.last));
                  chk("sb_src",    32'(bus.out_src),    32'(e.src));
               end
               tq.push_back(cyc);
               seen++;
            end
            for (int i = 0; i < NCH; i++)
               if (bus.in_valid[i] && bus.in_ready[i] && eng_q[i].size() != 0)
                  void'(eng_q[i].pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CW-1:0] held;
      tbl[0] = '{0, 4'd0,  5'b11111, 1, 16'h1000, 4'd0, 0};
      tbl[1] = '{0, 4'd4,  5'b10000, 1, 16'h1004, 4'd4, 0};
      tbl[2] = '{0, 4'd3,  5'b10111, 0, 16'h0000, 4'd0, 0};
      tbl[3] = '{0, 4'd10, 5'b11111, 0, 16'h0000, 4'd0, 0};
      tbl[4] = '{0, 4'd15, 5'b11111, 0, 16'h0000, 4'd0, 0};
      tbl[5] = '{0, 4'd5,  5'b11111, 1, 16'hF000, 4'd5, 1};
      tbl[6] = '{0, 4'd14, 5'b00000, 1, 16'hF000, 4'd14, 1};
      tbl[7] = '{1, 4'd15, 5'b00100, 1, 16'h1002, 4'd2, 0};
      tbl[8] = '{1, 4'd7,  5'b00000, 0, 16'h0000, 4'd0, 0};
      tbl[9] = '{1, 4'd5,  5'b01000, 1, 16'h1003, 4'd3, 0};

      rst = 1'b1; arb_mode = 1'b0; sel = 4'd15; bus.out_ready = 1'b1;
      raw = 1'b1; raw_valid = '0;
      tick();
      tick();
      chk("rst_out_valid",  32'(bus.out_valid),  0);
      chk("rst_out_colour", 32'(bus.out_colour), 0);
      chk("rst_out_last",   32'(bus.out_last),   0);
      chk("rst_out_src",    32'(bus.out_src),    0);
      chk("rst_in_ready",   32'(bus.in_ready),   0);
      chk("rst_busy",       32'(busy),           0);
      chk("rst_fault",      32'(fault),          0);

      // Opcode table: inputs applied under reset, result observed two edges after release.
      for (int k = 0; k < 10; k++) begin
         rst = 1'b1; arb_mode = tbl[k].arb; sel = tbl[k].sel; raw_valid = tbl[k].vmask;
         tick();
         rst = 1'b0;
         tick();
         tick();
         chk($sformatf("vec%0d_out_valid", k), 32'(bus.out_valid), 32'(tbl[k].ov));
         chk($sformatf("vec%0d_busy", k),      32'(busy),          32'(tbl[k].ov));
         chk($sformatf("vec%0d_fault", k),     32'(fault),         32'(tbl[k].flt));
         if (tbl[k].ov) begin
            chk($sformatf("vec%0d_colour", k), 32'(bus.out_colour), 32'(tbl[k].colour));
            chk($sformatf("vec%0d_src", k),    32'(bus.out_src),    32'(tbl[k].src));
         end
      end
      raw_valid = '0;
      raw = 1'b0;

      // 1: directed 3-beat burst at full throughput
      arb_mode = 1'b0; sel = 4'd2;
      do_reset();
      push_burst(2, 3, 16'hA000);
      drain("t1");
      chk("t1_nbeats", tq.size(), 3);
      if (tq.size() == 3) begin
         chk("t1_gap0", tq[1] - tq[0], 1);
         chk("t1_gap1", tq[2] - tq[1], 1);
      end
      tick();
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_idle_ready", 32'(bus.in_ready), 0);
`ifdef DRAW_MUX_BEATCNT_EN
      chk("t6_cnt_after_t1", beat_cnt, 3);
`endif

      // 2: downstream stall mid-burst
      do_reset();
      push_burst(2, 6, 16'hB000);
      wait_seen(2, "t2");
      bus.out_ready = 1'b0;
      held = bus.out_colour;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t2_stall_valid",  32'(bus.out_valid),   1);
         chk("t2_stall_colour", 32'(bus.out_colour),  32'(held));
         chk("t2_stall_ready",  32'(bus.in_ready[2]), 0);
      end
      bus.out_ready = 1'b1;
      drain("t2");
      chk("t2_nbeats", tq.size(), 6);

      // 3: round-robin over channels 0,1,4 with single-beat bursts
      arb_mode = 1'b1; sel = 4'd15;
      do_reset();
      for (int k = 0; k < 3; k++) eng_q[0].push_back('{colour: CW'(16'hC000 + k), last: 1'b1});
      for (int k = 0; k < 2; k++) eng_q[1].push_back('{colour: CW'(16'hC010 + k), last: 1'b1});
      for (int k = 0; k < 2; k++) eng_q[4].push_back('{colour: CW'(16'hC040 + k), last: 1'b1});
      exp_q.push_back('{colour: 16'hC000, last: 1'b1, src: 4'd0});
      exp_q.push_back('{colour: 16'hC010, last: 1'b1, src: 4'd1});
      exp_q.push_back('{colour: 16'hC040, last: 1'b1, src: 4'd4});
      exp_q.push_back('{colour: 16'hC001, last: 1'b1, src: 4'd0});
      exp_q.push_back('{colour: 16'hC011, last: 1'b1, src: 4'd1});
      exp_q.push_back('{colour: 16'hC041, last: 1'b1, src: 4'd4});
      exp_q.push_back('{colour: 16'hC002, last: 1'b1, src: 4'd0});
      drain("t3");
      chk("t3_nbeats", tq.size(), 7);
      for (int k = 1; k < tq.size(); k++)
         chk($sformatf("t3_gap%0d", k), tq[k] - tq[k-1], 2);

      // 4: unsupported opcode, then the idle opcode
      arb_mode = 1'b0; sel = 4'd15;
      do_reset();
      sel = 4'd7;
      exp_q.push_back('{colour: 16'hF000, last: 1'b1, src: 4'd7});
      tick();
      sel = 4'd15;
      tick();
      chk("t4_fault_set", 32'(fault), 1);
      drain("t4");
      for (int k = 0; k < 3; k++) tick();
      chk("t4_fault_sticky", 32'(fault), 1);
      chk("t4_idle_busy", 32'(busy), 0);
      chk("t4_nbeats", tq.size(), 1);

      // 5: reset in the middle of a burst, then a clean burst
      sel = 4'd2;
      do_reset();
      push_burst(2, 5, 16'hD000);
      wait_seen(2, "t5");
      rst = 1'b1;
      eng_q[2].delete();
      exp_q.delete();
      tick();
      chk("t5_rst_valid", 32'(bus.out_valid), 0);
      chk("t5_rst_ready", 32'(bus.in_ready), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tq.delete();
      push_burst(2, 2, 16'hE000);
      drain("t5");
      chk("t5_nbeats", tq.size(), 2);

`ifdef DRAW_MUX_BEATCNT_EN
      // 6: counter wraps from all-ones on one accepted beat
      dut.beat_cnt_r = 32'hFFFF_FFFF;
      push_burst(2, 1, 16'hE100);
      drain("t6");
      tick();
      chk("t6_cnt_wrap", beat_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
